// File: rtl/idct_pkg.sv
// idct_pkg: shared block-position codes, block size and zig-zag de-scan table
package idct_pkg;
  localparam logic [1:0] IDCT_IDLE  = 2'b00;
  localparam logic [1:0] IDCT_FIRST = 2'b01;
  localparam logic [1:0] IDCT_MID   = 2'b10;
  localparam logic [1:0] IDCT_LAST  = 2'b11;
  localparam int BLK_SIZE = 64;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;
  localparam logic [5:0] ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/idct_coef_feeder_if.sv
// idct_coef_feeder_if: coefficient input handshake plus IDCT-side sample stream
interface idct_coef_feeder_if #(parameter int DATA_W = 16);
  logic              in_valid;
  logic [DATA_W-1:0] in_coef;
  logic              in_ready;
  logic              start;
  logic [1:0]        idct;
  logic [DATA_W-1:0] x_out;
  logic              blk_done;
  modport master (output in_valid, in_coef, input in_ready, start, idct, x_out, blk_done);
  modport slave  (input in_valid, in_coef, output in_ready, start, idct, x_out, blk_done);
endinterface

// File: rtl/idct_pingpong_ram.sv
// idct_pingpong_ram: two 64-entry banks, one write port and one registered read port
module idct_pingpong_ram #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [6:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [6:0]        raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [128];
  logic [DATA_W-1:0] rdata_q;
  // bank select is the address MSB; contents are never cleared since full flags gate use
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/idct_coef_feeder.sv
// idct_coef_feeder: de-scans zig-zag coefficient blocks into a ping-pong buffer and streams them to the IDCT
module idct_coef_feeder
  import idct_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter bit ZIGZAG = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  idct_coef_feeder_if.slave bus
);
  rd_state_e         state_q, state_d;
  logic [5:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        code_q, code_d;
  logic              wr_en, wr_done, rd_last, next_ready;
  logic [5:0]        wr_addr;
  logic [DATA_W-1:0] rdata;

  assign wr_en      = bus.in_valid && !full_q[wr_bank_q];
  assign wr_done    = wr_en && wr_idx_q == 6'd63;
  assign wr_addr    = ZIGZAG ? ZZ_LUT[wr_idx_q] : wr_idx_q;
  assign rd_last    = state_q == RD_STREAM && rd_idx_q == 6'd63;
  assign next_ready = full_q[!rd_bank_q] || (wr_done && wr_bank_q != rd_bank_q);

  // writer: advance index per accepted beat, mark bank full and swap on the 64th beat
  always_comb begin
    wr_idx_d  = wr_en ? wr_idx_q + 6'd1 : wr_idx_q;
    wr_bank_d = wr_bank_q ^ wr_done;
    full_d    = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
  end

  // reader: wait for a full bank, then issue 64 consecutive reads, chaining into the
  // other bank without a gap when it is full (or completes this very cycle)
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    code_d    = IDCT_IDLE;
    if (state_q == RD_IDLE) begin
      state_d  = full_q[rd_bank_q] ? RD_STREAM : RD_IDLE;
      rd_idx_d = 6'd0;
    end else begin
      code_d   = rd_idx_q == 6'd0 ? IDCT_FIRST : rd_last ? IDCT_LAST : IDCT_MID;
      rd_idx_d = rd_idx_q + 6'd1;
      if (rd_last) begin
        rd_bank_d = !rd_bank_q;
        state_d   = next_ready ? RD_STREAM : RD_IDLE;
      end
    end
  end

  // state, pointers, flags and the output code that tracks the registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RD_IDLE;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      code_q    <= IDCT_IDLE;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      code_q    <= code_d;
    end
  end

  idct_pingpong_ram #(.DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank_q, wr_addr}),
    .wdata (bus.in_coef),
    .raddr ({rd_bank_q, rd_idx_q}),
    .rdata (rdata)
  );

  assign bus.in_ready = !full_q[wr_bank_q];
  assign bus.idct     = code_q;
  assign bus.start    = code_q == IDCT_FIRST;
  assign bus.blk_done = code_q == IDCT_LAST;
  assign bus.x_out    = code_q != IDCT_IDLE ? rdata : '0;
endmodule
